// File: rtl/sgf_mult_norm_round.sv
// Post-multiply normalize/round stage: takes the raw 2*SW-bit significand product and
// returns the rounded SW-bit significand, exponent increment and inexact flag. Optional macro SGF_NR_IN_REG_EN adds an input register stage.
module sgf_mult_norm_round #(
    parameter int SW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*SW-1:0] sgf_prod_i,
    input  logic            sign_i,
    input  logic [1:0]      rmode_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [SW-1:0]   sgf_o,
    output logic [1:0]      exp_inc_o,
    output logic            inexact_o,
    output logic            sign_o,
    output logic            valid_o,
    input  logic            ready_i
);

    localparam logic [1:0] RM_RNE  = 2'b00;
    localparam logic [1:0] RM_RTZ  = 2'b01;
    localparam logic [1:0] RM_PINF = 2'b10;

    logic            en;
    logic [2*SW-1:0] nrm_prod;
    logic            nrm_sign;
    logic [1:0]      nrm_rmode;
    logic            nrm_valid;

    assign en      = ~valid_o | ready_i;
    assign ready_o = en;

`ifdef SGF_NR_IN_REG_EN
    logic [2*SW-1:0] prod_in_q;
    logic            sign_in_q;
    logic [1:0]      rmode_in_q;
    logic            valid_in_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_in_q  <= '0;
            sign_in_q  <= 1'b0;
            rmode_in_q <= 2'b00;
            valid_in_q <= 1'b0;
        end else if (en) begin
            prod_in_q  <= sgf_prod_i;
            sign_in_q  <= sign_i;
            rmode_in_q <= rmode_i;
            valid_in_q <= valid_i;
        end
    end

    assign nrm_prod  = prod_in_q;
    assign nrm_sign  = sign_in_q;
    assign nrm_rmode = rmode_in_q;
    assign nrm_valid = valid_in_q;
`else
    assign nrm_prod  = sgf_prod_i;
    assign nrm_sign  = sign_i;
    assign nrm_rmode = rmode_i;
    assign nrm_valid = valid_i;
`endif

    // Normalize: a product of two [1,2) significands lies in [1,4), so at most one right shift.
    logic [SW-1:0] m1_d;
    logic          g1_d;
    logic          s1_d;
    logic          e1_d;

    always_comb begin
        m1_d = nrm_prod[2*SW-2:SW-1];
        g1_d = nrm_prod[SW-2];
        s1_d = |nrm_prod[SW-3:0];
        e1_d = 1'b0;
        if (nrm_prod[2*SW-1]) begin
            m1_d = nrm_prod[2*SW-1:SW];
            g1_d = nrm_prod[SW-1];
            s1_d = |nrm_prod[SW-2:0];
            e1_d = 1'b1;
        end
    end

    logic          v1_q;
    logic [SW-1:0] m1_q;
    logic          g1_q;
    logic          s1_q;
    logic          e1_q;
    logic          sign1_q;
    logic [1:0]    rmode1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q     <= 1'b0;
            m1_q     <= '0;
            g1_q     <= 1'b0;
            s1_q     <= 1'b0;
            e1_q     <= 1'b0;
            sign1_q  <= 1'b0;
            rmode1_q <= 2'b00;
        end else if (en) begin
            v1_q     <= nrm_valid;
            m1_q     <= m1_d;
            g1_q     <= g1_d;
            s1_q     <= s1_d;
            e1_q     <= e1_d;
            sign1_q  <= nrm_sign;
            rmode1_q <= nrm_rmode;
        end
    end

    logic          inc;
    logic [SW:0]   rnd_sum;
    logic [SW-1:0] sgf_d;
    logic [1:0]    exp_inc_d;

    always_comb begin
        inc = 1'b0;
        case (rmode1_q)
            RM_RNE:  inc = g1_q & (s1_q | m1_q[0]);
            RM_RTZ:  inc = 1'b0;
            RM_PINF: inc = ~sign1_q & (g1_q | s1_q);
            default: inc = sign1_q & (g1_q | s1_q);
        endcase
        rnd_sum   = {1'b0, m1_q} + {{SW{1'b0}}, inc};
        sgf_d     = rnd_sum[SW-1:0];
        exp_inc_d = {1'b0, e1_q};
        // Carry out only happens from an all-ones mantissa, so the result is exactly 1.0 * 2.
        if (rnd_sum[SW]) begin
            sgf_d     = {1'b1, {(SW-1){1'b0}}};
            exp_inc_d = {1'b0, e1_q} + 2'd1;
        end
    end

    logic          valid_q;
    logic [SW-1:0] sgf_q;
    logic [1:0]    exp_inc_q;
    logic          inexact_q;
    logic          sign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            sgf_q     <= '0;
            exp_inc_q <= 2'd0;
            inexact_q <= 1'b0;
            sign_q    <= 1'b0;
        end else if (en) begin
            valid_q   <= v1_q;
            sgf_q     <= sgf_d;
            exp_inc_q <= exp_inc_d;
            inexact_q <= g1_q | s1_q;
            sign_q    <= sign1_q;
        end
    end

    assign valid_o   = valid_q;
    assign sgf_o     = sgf_q;
    assign exp_inc_o = exp_inc_q;
    assign inexact_o = inexact_q;
    assign sign_o    = sign_q;

endmodule

// File: tb/tb_sgf_mult_norm_round.sv
// Scoreboard bench for sgf_mult_norm_round (SW=24); directed vectors with hand-computed results.
// Honours SGF_NR_IN_REG_EN for the expected latency.
module tb_sgf_mult_norm_round;

    localparam int SW = 24;
`ifdef SGF_NR_IN_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    localparam logic [1:0] RNE  = 2'b00;
    localparam logic [1:0] RTZ  = 2'b01;
    localparam logic [1:0] PINF = 2'b10;
    localparam logic [1:0] MINF = 2'b11;

    logic            clk;
    logic            rst;
    logic [2*SW-1:0] sgf_prod_i;
    logic            sign_i;
    logic [1:0]      rmode_i;
    logic            valid_i;
    logic            ready_o;
    logic [SW-1:0]   sgf_o;
    logic [1:0]      exp_inc_o;
    logic            inexact_o;
    logic            sign_o;
    logic            valid_o;
    logic            ready_i;

    sgf_mult_norm_round #(.SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sgf_prod_i (sgf_prod_i),
        .sign_i     (sign_i),
        .rmode_i    (rmode_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .sgf_o      (sgf_o),
        .exp_inc_o  (exp_inc_o),
        .inexact_o  (inexact_o),
        .sign_o     (sign_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] sgf;
        logic [1:0]    e;
        logic          inx;
        logic          sgn;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Monitor: every output beat accepted downstream is matched against the queue head.
    always @(negedge clk) begin
        if (rst && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: got sgf 0x%0h with nothing outstanding at %0t", sgf_o, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("beat_sgf",     64'(sgf_o),     64'(e.sgf));
                chk("beat_exp_inc", 64'(exp_inc_o), 64'(e.e));
                chk("beat_inexact", 64'(inexact_o), 64'(e.inx));
                chk("beat_sign",    64'(sign_o),    64'(e.sgn));
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
    task automatic send(input logic [2*SW-1:0] prod, input logic sgn, input logic [1:0] rm,
                        input logic [SW-1:0] x_sgf, input logic [1:0] x_e, input logic x_inx);
        exp_t e;
        int   waited;
        sgf_prod_i = prod;
        sign_i     = sgn;
        rmode_i    = rm;
        valid_i    = 1'b1;
        e.sgf = x_sgf; e.e = x_e; e.inx = x_inx; e.sgn = sgn;
        exp_q.push_back(e);
        waited = 0;
        @(negedge clk);
        while (!ready_o && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!ready_o) begin
            n_checks++;
            $display("FAIL send_timeout: ready_o stuck low for %0d cycles", waited);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        rst        = 1'b0;
        sgf_prod_i = '0;
        sign_i     = 1'b0;
        rmode_i    = RNE;
        valid_i    = 1'b0;
        ready_i    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",   64'(valid_o),   64'd0);
        chk("rst_ready",   64'(ready_o),   64'd1);
        chk("rst_sgf",     64'(sgf_o),     64'd0);
        chk("rst_exp_inc", 64'(exp_inc_o), 64'd0);
        chk("rst_inexact", 64'(inexact_o), 64'd0);
        chk("rst_sign",    64'(sign_o),    64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Latency on an empty pipeline.
        send(48'h400000000000, 1'b0, RNE, 24'h800000, 2'd0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_o) break;
            @(posedge clk);
            cnt++;
        end
        chk("latency", 64'(cnt + 1), 64'(LAT));
        drain("drain_first");

        // Back-to-back directed vectors.
        send(48'hFFFFFE000001, 1'b0, RNE,  24'hFFFFFE, 2'd1, 1'b1);
        send(48'hFFFFFE000001, 1'b0, PINF, 24'hFFFFFF, 2'd1, 1'b1);
        send(48'hFFFFFE000001, 1'b0, MINF, 24'hFFFFFE, 2'd1, 1'b1);
        send(48'hFFFFFE000001, 1'b1, MINF, 24'hFFFFFF, 2'd1, 1'b1);
        send(48'hFFFFFE000001, 1'b1, PINF, 24'hFFFFFE, 2'd1, 1'b1);
        send(48'h800000800000, 1'b0, RNE,  24'h800000, 2'd1, 1'b1);
        send(48'hFFFFFF800000, 1'b0, RNE,  24'h800000, 2'd2, 1'b1);
        send(48'hFFFFFF800000, 1'b0, RTZ,  24'hFFFFFF, 2'd1, 1'b1);
        send(48'h400000C00000, 1'b0, RNE,  24'h800002, 2'd0, 1'b1);
        send(48'h7FFFFFC00000, 1'b1, RNE,  24'h800000, 2'd1, 1'b1);
        send(48'h000000000000, 1'b0, RNE,  24'h000000, 2'd0, 1'b0);
        drain("drain_stream");

        // Backpressure: stall once the first beat reaches the output.
        fork
            begin
                send(48'hFFFFFE000001, 1'b0, RTZ, 24'hFFFFFE, 2'd1, 1'b1);
                send(48'h400000C00000, 1'b0, RNE, 24'h800002, 2'd0, 1'b1);
                send(48'hFFFFFF800000, 1'b0, RNE, 24'h800000, 2'd2, 1'b1);
                send(48'h000000000000, 1'b0, RNE, 24'h000000, 2'd0, 1'b0);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk);
                    #1;
                    if (valid_o) break;
                end
                ready_i = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("stall_ready_o", 64'(ready_o),   64'd0);
                    chk("stall_valid_o", 64'(valid_o),   64'd1);
                    chk("stall_sgf",     64'(sgf_o),     64'hFFFFFE);
                    chk("stall_exp_inc", 64'(exp_inc_o), 64'd1);
                end
                @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Asynchronous reset with beats in flight.
        send(48'hFFFFFF800000, 1'b1, RNE, 24'h800000, 2'd2, 1'b1);
        send(48'hFFFFFE000001, 1'b1, MINF, 24'hFFFFFF, 2'd1, 1'b1);
        rst = 1'b0;
        #1;
        chk("arst_valid",   64'(valid_o),   64'd0);
        chk("arst_sgf",     64'(sgf_o),     64'd0);
        chk("arst_exp_inc", 64'(exp_inc_o), 64'd0);
        chk("arst_inexact", 64'(inexact_o), 64'd0);
        chk("arst_sign",    64'(sign_o),    64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(valid_o), 64'd0);
        end
        @(posedge clk);
        #1;
        send(48'h800000800000, 1'b0, RNE, 24'h800000, 2'd1, 1'b1);
        drain("drain_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
